// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the encoder and decoder sides of Gray-coded links.
// Functions operate on 16-bit containers; callers zero-extend narrower words.
package gray_pkg;

    localparam int unsigned GRAY_DEFAULT_WIDTH = 4;
    localparam int unsigned GRAY_MAX_WIDTH     = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_TRACK = 1'b1
    } track_state_t;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bits at or above w are cleared first so they cannot leak into the prefix XOR.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g,
                                                           input int unsigned w);
        logic [GRAY_MAX_WIDTH-1:0] gm;
        logic [GRAY_MAX_WIDTH-1:0] b;
        gm = g;
        b  = '0;
        for (int unsigned i = 0; i < GRAY_MAX_WIDTH; i++) begin
            if (i >= w) gm[i] = 1'b0;
        end
        for (int unsigned i = 0; i < GRAY_MAX_WIDTH; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

    function automatic logic [4:0] popcount(input logic [GRAY_MAX_WIDTH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int unsigned i = 0; i < GRAY_MAX_WIDTH; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_comb #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_to_bin_stream.sv
// Streaming Gray-to-binary decoder with one registered output stage and
// step monitoring (single-bit step check, up-step flag, saturating error count).
module gray_to_bin_stream
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH     = GRAY_DEFAULT_WIDTH,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_gray,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_bin,
    output logic                 out_step_err,
    output logic                 out_up,
    output logic [ERR_CNT_W-1:0] err_count
);

    track_state_t r_state, w_state_next;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_bin;
    logic                 r_out_step_err;
    logic                 r_out_up;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [WIDTH-1:0]     r_prev_gray;
    logic [WIDTH-1:0]     r_prev_bin;

    logic                      w_accept;
    logic [WIDTH-1:0]          w_bin;
    logic [GRAY_MAX_WIDTH-1:0] w_diff;
    logic [4:0]                w_pop;
    logic                      w_step_err;
    logic                      w_up;

    gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
        .i_gray (in_gray),
        .o_bin  (w_bin)
    );

    assign in_ready = !r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_diff   = GRAY_MAX_WIDTH'(in_gray ^ r_prev_gray);
    assign w_pop    = popcount(w_diff);

    always_comb begin
        w_state_next = r_state;
        w_step_err   = 1'b0;
        w_up         = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_state_next = ST_TRACK;
            end
            ST_TRACK: begin
                w_step_err = (w_pop != 5'd1);
                w_up       = !w_step_err && (w_bin == r_prev_bin + WIDTH'(1));
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_EMPTY;
            r_out_valid    <= 1'b0;
            r_out_bin      <= '0;
            r_out_step_err <= 1'b0;
            r_out_up       <= 1'b0;
            r_err_count    <= '0;
            r_prev_gray    <= '0;
            r_prev_bin     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_out_valid    <= 1'b1;
                r_out_bin      <= w_bin;
                r_out_step_err <= w_step_err;
                r_out_up       <= w_up;
                r_prev_gray    <= in_gray;
                r_prev_bin     <= w_bin;
                if (w_step_err && (r_err_count != '1)) begin
                    r_err_count <= r_err_count + ERR_CNT_W'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_bin      = r_out_bin;
    assign out_step_err = r_out_step_err;
    assign out_up       = r_out_up;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_gray_to_bin_stream.sv
// Self-checking bench for gray_to_bin_stream: directed scenarios plus randomized
// traffic compared against an arithmetic reference model with an expected-word queue.
module tb_gray_to_bin_stream;

    localparam int unsigned W  = 4;
    localparam int unsigned EW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_gray;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_bin;
    logic          out_step_err;
    logic          out_up;
    logic [EW-1:0] err_count;

    typedef struct {
        int unsigned bin;
        bit          err;
        bit          up;
    } exp_t;

    exp_t        q[$];
    bit          m_have;
    int unsigned m_prev_bin;
    int unsigned m_errs;
    int unsigned n_acc;
    int unsigned n_drain;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    gray_to_bin_stream #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_gray      (in_gray),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bin      (out_bin),
        .out_step_err (out_step_err),
        .out_up       (out_up),
        .err_count    (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned m_g2b(input int unsigned g);
        int unsigned b;
        b = g;
        for (int unsigned s = g >> 1; s != 0; s = s >> 1) b = b ^ s;
        return b;
    endfunction

    function automatic int unsigned m_b2g(input int unsigned b);
        return b ^ (b >> 1);
    endfunction

    // One clock: compare DUT state at negedge, advance the model with this cycle's inputs.
    task automatic cycle();
        exp_t        e;
        int unsigned b;
        int unsigned gi;
        bit          rdy;
        @(negedge clk);
        rdy = (q.size() == 0) || out_ready;
        check("out_valid", out_valid, (q.size() != 0));
        check("in_ready", in_ready, rdy);
        check("err_count", err_count, m_errs);
        if (q.size() != 0) begin
            check("out_bin", out_bin, q[0].bin);
            check("step_err", out_step_err, q[0].err);
            check("up", out_up, q[0].up);
        end
        if (rst) begin
            n_acc      = n_acc - q.size();
            q.delete();
            m_have     = 0;
            m_prev_bin = 0;
            m_errs     = 0;
        end else begin
            if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
                n_drain++;
            end
            if (in_valid && rdy) begin
                gi = in_gray;
                b  = m_g2b(gi);
                if (!m_have) begin
                    e.err = 0;
                    e.up  = 0;
                end else begin
                    e.err = ($countones(gi ^ m_b2g(m_prev_bin)) != 1);
                    e.up  = !e.err && (b == ((m_prev_bin + 1) % (1 << W)));
                end
                e.bin = b;
                if (e.err && m_errs < (1 << EW) - 1) m_errs++;
                m_have     = 1;
                m_prev_bin = b;
                q.push_back(e);
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] g, input logic ordy);
        in_valid  = v;
        in_gray   = g;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int unsigned cur;
        logic [3:0]  up_run [5];
        up_run[0] = 4'b0000;
        up_run[1] = 4'b0001;
        up_run[2] = 4'b0011;
        up_run[3] = 4'b0010;
        up_run[4] = 4'b0110;
        m_have = 0; m_prev_bin = 0; m_errs = 0; n_acc = 0; n_drain = 0;

        rst = 1'b1;
        drive(1'b0, '0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_step_err", out_step_err, 0);
        check("rst_up", out_up, 0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready", in_ready, 1);

        // Single word after reset
        drive(1'b1, 4'b0110, 1'b1);
        cycle();
        drive(1'b0, '0, 1'b1);
        check("single_bin", out_bin, 4'b0100);
        check("single_err", out_step_err, 0);
        check("single_up", out_up, 0);
        cycle();

        // Full-rate up run
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, up_run[i], 1'b1);
            cycle();
            check("run_bin", out_bin, i);
            check("run_err", out_step_err, 0);
            check("run_up", out_up, (i > 0));
        end
        drive(1'b0, '0, 1'b1);
        cycle();

        // Illegal jump then resync
        do_reset();
        drive(1'b1, 4'b0010, 1'b1); cycle();
        drive(1'b1, 4'b0111, 1'b1); cycle();
        check("jump_bin", out_bin, 4'b0101);
        check("jump_err", out_step_err, 1);
        check("jump_up", out_up, 0);
        check("jump_cnt", err_count, 1);
        drive(1'b1, 4'b0101, 1'b1); cycle();
        check("resync_bin", out_bin, 4'b0110);
        check("resync_err", out_step_err, 0);
        check("resync_up", out_up, 1);

        // Wrap-around and repeat
        do_reset();
        drive(1'b1, 4'b1000, 1'b1); cycle();
        check("wrap_hi_bin", out_bin, 4'b1111);
        drive(1'b1, 4'b0000, 1'b1); cycle();
        check("wrap_bin", out_bin, 0);
        check("wrap_up", out_up, 1);
        check("wrap_err", out_step_err, 0);
        drive(1'b1, 4'b0000, 1'b1); cycle();
        check("repeat_err", out_step_err, 1);
        check("repeat_cnt", err_count, 1);

        // Backpressure
        do_reset();
        drive(1'b1, 4'b0000, 1'b1); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0001, 1'b0);
            cycle();
            check("bp_in_ready", in_ready, 0);
            check("bp_bin", out_bin, 0);
        end
        drive(1'b1, 4'b0001, 1'b1); cycle();
        check("bp_next_bin", out_bin, 1);
        check("bp_next_up", out_up, 1);
        drive(1'b0, '0, 1'b1); cycle();

        // Reset while stalled
        drive(1'b1, 4'b0011, 1'b1); cycle();
        drive(1'b0, '0, 1'b0); cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        check("mrst_valid", out_valid, 0);
        check("mrst_bin", out_bin, 0);
        check("mrst_cnt", err_count, 0);
        check("mrst_in_ready", in_ready, 1);
        drive(1'b1, 4'b0110, 1'b1); cycle();
        check("mrst_first_err", out_step_err, 0);
        drive(1'b0, '0, 1'b1); cycle();

        // Saturation of the 2-bit error counter
        do_reset();
        drive(1'b1, 4'b0000, 1'b1); cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0000, 1'b1);
            cycle();
        end
        check("sat_cnt", err_count, 3);
        drive(1'b0, '0, 1'b1); cycle();

        // Randomized traffic
        do_reset();
        cur = 0;
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 50)      cur = (cur + 1) % (1 << W);
            else if (r < 70) cur = (cur + (1 << W) - 1) % (1 << W);
            else if (r < 80) cur = cur;
            else             cur = $urandom_range(0, (1 << W) - 1);
            drive(($urandom_range(0, 3) != 0), W'(m_b2g(cur)), ($urandom_range(0, 3) != 0));
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        drive(1'b0, '0, 1'b1);
        cycle();
        cycle();
        check("no_loss", n_drain, n_acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
